// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: default widths, reset PC
// and the request-tracking FSM state encoding.
package fetch_pkg;

  localparam int unsigned INSTR_W_DEF  = 34;
  localparam int unsigned ADDR_W_DEF   = 18;
  localparam int unsigned RESET_PC_DEF = 0;

  // StFetch: nothing outstanding; StWait: live request outstanding;
  // StDrain: stale request outstanding, its response is thrown away.
  typedef enum logic [1:0] {
    StFetch = 2'd0,
    StWait  = 2'd1,
    StDrain = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_if.sv
// Fetch unit bus bundle: instruction memory request/response, redirect input
// and the decode-side valid/ready handshake.
interface fetch_if
  import fetch_pkg::*;
#(
  parameter int unsigned INSTR_W = INSTR_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF
);

  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [ADDR_W-1:0]  imem_req_addr;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               id_valid;
  logic               id_ready;
  logic [INSTR_W-1:0] id_instr;
  logic [ADDR_W-1:0]  id_pc;

  // Fetch unit side
  modport master (
    output imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
           id_ready
  );

  // Memory / pipeline environment side
  modport slave (
    input  imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
           id_ready
  );

endinterface

// File: rtl/fetch_queue.sv
// Two-entry {pc, instr} FIFO between the fetch FSM and decode, with flush.
// Head entry is driven straight from storage so it holds steady during stalls.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned INSTR_W = INSTR_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic               i_flush,
  input  logic [ADDR_W-1:0]  i_push_pc,
  input  logic [INSTR_W-1:0] i_push_instr,
  output logic [ADDR_W-1:0]  o_head_pc,
  output logic [INSTR_W-1:0] o_head_instr,
  output logic [1:0]         o_count
);

  logic [ADDR_W-1:0]  r_pc_mem    [2];
  logic [INSTR_W-1:0] r_instr_mem [2];
  logic               r_rd_ptr;
  logic               r_wr_ptr;
  logic [1:0]         r_count;

  logic w_push;
  logic w_pop;

  // Defensive qualification; the fetch FSM never pushes full or pops empty.
  assign w_pop  = i_pop & (r_count != 2'd0);
  assign w_push = i_push & ((r_count != 2'd2) | w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_pc_mem[i]    <= '0;
        r_instr_mem[i] <= '0;
      end
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_pc_mem[r_wr_ptr]    <= i_push_pc;
        r_instr_mem[r_wr_ptr] <= i_push_instr;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 2'd1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 2'd1;
      end
    end
  end

  assign o_head_pc    = r_pc_mem[r_rd_ptr];
  assign o_head_instr = r_instr_mem[r_rd_ptr];
  assign o_count      = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC, single-outstanding-request FSM and redirect
// handling, feeding decode through a two-entry queue.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned INSTR_W  = INSTR_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned RESET_PC = RESET_PC_DEF
) (
  input  logic     clk,
  input  logic     rst_n,
  fetch_if.master  bus
);

  fetch_state_e      r_state;
  fetch_state_e      w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] r_issued_pc;
  logic [ADDR_W-1:0] w_issued_pc_nxt;

  logic [1:0]         w_count;
  logic [ADDR_W-1:0]  w_head_pc;
  logic [INSTR_W-1:0] w_head_instr;

  logic w_req_valid;
  logic w_req_fire;
  logic w_id_valid;
  logic w_push;
  logic w_pop;

  // rst_n gates the request so nothing is offered while reset is held, yet the
  // first request appears in the very first cycle after release.
  assign w_req_valid = rst_n & (r_state == StFetch) & (w_count != 2'd2) & ~bus.redirect_valid;
  assign w_req_fire  = w_req_valid & bus.imem_req_ready;
  assign w_id_valid  = (w_count != 2'd0) & ~bus.redirect_valid;
  assign w_pop       = w_id_valid & bus.id_ready;
  assign w_push      = (r_state == StWait) & bus.imem_rsp_valid & ~bus.redirect_valid;

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_issued_pc_nxt = r_issued_pc;

    unique case (r_state)
      StFetch: begin
        if (bus.redirect_valid) begin
          w_pc_nxt = bus.redirect_pc;
        end else if (w_req_fire) begin
          w_pc_nxt        = r_pc + ADDR_W'(1);
          w_issued_pc_nxt = r_pc;
          w_state_nxt     = StWait;
        end
      end
      StWait: begin
        if (bus.redirect_valid) begin
          w_pc_nxt    = bus.redirect_pc;
          w_state_nxt = bus.imem_rsp_valid ? StFetch : StDrain;
        end else if (bus.imem_rsp_valid) begin
          w_state_nxt = StFetch;
        end
      end
      StDrain: begin
        if (bus.redirect_valid) begin
          w_pc_nxt = bus.redirect_pc;
        end
        if (bus.imem_rsp_valid) begin
          w_state_nxt = StFetch;
        end
      end
      default: begin
        w_state_nxt = StFetch;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StFetch;
      r_pc        <= ADDR_W'(RESET_PC);
      r_issued_pc <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_issued_pc <= w_issued_pc_nxt;
    end
  end

  fetch_queue #(
    .INSTR_W (INSTR_W),
    .ADDR_W  (ADDR_W)
  ) u_queue (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_push       (w_push),
    .i_pop        (w_pop),
    .i_flush      (bus.redirect_valid),
    .i_push_pc    (r_issued_pc),
    .i_push_instr (bus.imem_rsp_data),
    .o_head_pc    (w_head_pc),
    .o_head_instr (w_head_instr),
    .o_count      (w_count)
  );

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_pc;
  assign bus.id_valid       = w_id_valid;
  assign bus.id_instr       = w_head_instr;
  assign bus.id_pc          = w_head_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a per-cycle vector table for streaming,
// stall, redirect and wrap cases, plus a hand-written mid-request reset.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int unsigned IW = 34;
  localparam int unsigned AW = 18;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_if #(.INSTR_W(IW), .ADDR_W(AW)) bus ();

  fetch_unit #(
    .INSTR_W  (IW),
    .ADDR_W   (AW),
    .RESET_PC (0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic          rdy;
    logic          rv;
    logic [AW-1:0] rsp_addr;
    logic          redir;
    logic [AW-1:0] rpc;
    logic          idr;
    logic          e_rqv;
    logic [AW-1:0] e_addr;
    logic          e_idv;
    logic [AW-1:0] e_idpc;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [IW-1:0] word_of(input logic [AW-1:0] a);
    return {16'hBEEF, a};
  endfunction

  function automatic vec_t mk(input logic rdy, input logic rv, input logic [AW-1:0] rsp_addr,
                              input logic redir, input logic [AW-1:0] rpc, input logic idr,
                              input logic e_rqv, input logic [AW-1:0] e_addr,
                              input logic e_idv, input logic [AW-1:0] e_idpc);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rsp_addr = rsp_addr; v.redir = redir; v.rpc = rpc; v.idr = idr;
    v.e_rqv = e_rqv; v.e_addr = e_addr; v.e_idv = e_idv; v.e_idpc = e_idpc;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rdy, input logic rv, input logic [AW-1:0] rsp_addr,
                       input logic redir, input logic [AW-1:0] rpc, input logic idr);
    bus.imem_req_ready = rdy;
    bus.imem_rsp_valid = rv;
    bus.imem_rsp_data  = word_of(rsp_addr);
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    bus.id_ready       = idr;
  endtask

  initial begin
    // Stream 0,1,2 then stall decode to fill the queue and drain it in order.
    vecs.push_back(mk(1, 0, 'h0,     0, 'h0,     1,  1, 'h0,     0, 'h0));
    vecs.push_back(mk(1, 1, 'h0,     0, 'h0,     1,  0, 'h1,     0, 'h0));
    vecs.push_back(mk(1, 0, 'h0,     0, 'h0,     1,  1, 'h1,     1, 'h0));
    vecs.push_back(mk(1, 1, 'h1,     0, 'h0,     1,  0, 'h2,     0, 'h0));
    vecs.push_back(mk(1, 0, 'h0,     0, 'h0,     1,  1, 'h2,     1, 'h1));
    vecs.push_back(mk(1, 1, 'h2,     0, 'h0,     1,  0, 'h3,     0, 'h0));
    vecs.push_back(mk(1, 0, 'h0,     0, 'h0,     0,  1, 'h3,     1, 'h2));
    vecs.push_back(mk(1, 1, 'h3,     0, 'h0,     0,  0, 'h4,     1, 'h2));
    vecs.push_back(mk(1, 0, 'h0,     0, 'h0,     0,  0, 'h4,     1, 'h2));
    vecs.push_back(mk(1, 0, 'h0,     0, 'h0,     0,  0, 'h4,     1, 'h2));
    vecs.push_back(mk(1, 0, 'h0,     0, 'h0,     1,  0, 'h4,     1, 'h2));
    vecs.push_back(mk(1, 0, 'h0,     0, 'h0,     0,  1, 'h4,     1, 'h3));
    vecs.push_back(mk(1, 1, 'h4,     0, 'h0,     1,  0, 'h5,     1, 'h3));
    vecs.push_back(mk(0, 0, 'h0,     0, 'h0,     1,  1, 'h5,     1, 'h4));
    vecs.push_back(mk(0, 0, 'h0,     0, 'h0,     1,  1, 'h5,     0, 'h0));
    // Redirect while waiting: stale response for pc 5 must be dropped.
    vecs.push_back(mk(1, 0, 'h0,     0, 'h0,     1,  1, 'h5,     0, 'h0));
    vecs.push_back(mk(0, 0, 'h0,     1, 'h100,   1,  0, 'h6,     0, 'h0));
    vecs.push_back(mk(1, 0, 'h0,     0, 'h0,     1,  0, 'h100,   0, 'h0));
    vecs.push_back(mk(1, 1, 'h5,     0, 'h0,     1,  0, 'h100,   0, 'h0));
    vecs.push_back(mk(1, 0, 'h0,     0, 'h0,     1,  1, 'h100,   0, 'h0));
    vecs.push_back(mk(1, 1, 'h100,   0, 'h0,     1,  0, 'h101,   0, 'h0));
    vecs.push_back(mk(0, 0, 'h0,     0, 'h0,     1,  1, 'h101,   1, 'h100));
    // Redirect coincident with a response, with one entry queued.
    vecs.push_back(mk(1, 0, 'h0,     0, 'h0,     0,  1, 'h101,   0, 'h0));
    vecs.push_back(mk(1, 1, 'h101,   0, 'h0,     0,  0, 'h102,   0, 'h0));
    vecs.push_back(mk(1, 0, 'h0,     0, 'h0,     0,  1, 'h102,   1, 'h101));
    vecs.push_back(mk(1, 1, 'h102,   1, 'h200,   0,  0, 'h103,   0, 'h0));
    vecs.push_back(mk(1, 0, 'h0,     0, 'h0,     0,  1, 'h200,   0, 'h0));
    // Redirect in FETCH to the top address, then wrap to zero.
    vecs.push_back(mk(1, 1, 'h200,   0, 'h0,     0,  0, 'h201,   0, 'h0));
    vecs.push_back(mk(1, 0, 'h0,     1, 'h3FFFF, 1,  0, 'h201,   0, 'h0));
    vecs.push_back(mk(1, 0, 'h0,     0, 'h0,     1,  1, 'h3FFFF, 0, 'h0));
    vecs.push_back(mk(1, 1, 'h3FFFF, 0, 'h0,     1,  0, 'h0,     0, 'h0));
    vecs.push_back(mk(0, 0, 'h0,     0, 'h0,     1,  1, 'h0,     1, 'h3FFFF));
    // Response with nothing outstanding is ignored.
    vecs.push_back(mk(0, 1, 'h77,    0, 'h0,     1,  1, 'h0,     0, 'h0));
    vecs.push_back(mk(0, 0, 'h0,     0, 'h0,     1,  1, 'h0,     0, 'h0));

    drive(0, 0, '0, 0, '0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset req_valid", 64'(bus.imem_req_valid), 64'd0);
    check("reset req_addr", 64'(bus.imem_req_addr), 64'd0);
    check("reset id_valid", 64'(bus.id_valid), 64'd0);
    check("reset id_pc", 64'(bus.id_pc), 64'd0);
    check("reset id_instr", 64'(bus.id_instr), 64'd0);

    @(posedge clk);
    #1 rst_n = 1'b1;
    foreach (vecs[i]) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      drive(vecs[i].rdy, vecs[i].rv, vecs[i].rsp_addr, vecs[i].redir, vecs[i].rpc, vecs[i].idr);
      @(negedge clk);
      check($sformatf("row%0d req_valid", i), 64'(bus.imem_req_valid), 64'(vecs[i].e_rqv));
      check($sformatf("row%0d req_addr", i), 64'(bus.imem_req_addr), 64'(vecs[i].e_addr));
      check($sformatf("row%0d id_valid", i), 64'(bus.id_valid), 64'(vecs[i].e_idv));
      if (vecs[i].e_idv) begin
        check($sformatf("row%0d id_pc", i), 64'(bus.id_pc), 64'(vecs[i].e_idpc));
        check($sformatf("row%0d id_instr", i), 64'(bus.id_instr), 64'(word_of(vecs[i].e_idpc)));
      end
    end

    // Reset while a request is outstanding and one entry is queued.
    @(posedge clk); #1 drive(1, 0, '0, 0, '0, 0);
    @(posedge clk); #1 drive(0, 1, 'h0, 0, '0, 0);
    @(posedge clk); #1 drive(1, 0, '0, 0, '0, 0);
    @(negedge clk);
    check("prerst req_addr", 64'(bus.imem_req_addr), 64'h1);
    check("prerst id_pc", 64'(bus.id_pc), 64'h0);
    @(posedge clk); #1 drive(0, 0, '0, 0, '0, 0);
    #2;
    check("prerst id_valid", 64'(bus.id_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst id_valid", 64'(bus.id_valid), 64'd0);
    check("rst req_valid", 64'(bus.imem_req_valid), 64'd0);
    check("rst id_instr", 64'(bus.id_instr), 64'd0);
    check("rst req_addr", 64'(bus.imem_req_addr), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(0, 1, 'h1, 0, '0, 0);
    @(negedge clk);
    check("postrst req_valid", 64'(bus.imem_req_valid), 64'd1);
    check("postrst req_addr", 64'(bus.imem_req_addr), 64'd0);
    @(posedge clk); #1 drive(0, 0, '0, 0, '0, 0);
    @(negedge clk);
    check("stray id_valid", 64'(bus.id_valid), 64'd0);
    check("stray req_valid", 64'(bus.imem_req_valid), 64'd1);
    @(posedge clk); #1 drive(1, 0, '0, 0, '0, 0);
    @(negedge clk);
    check("restart req_addr", 64'(bus.imem_req_addr), 64'd0);
    @(posedge clk); #1 drive(0, 1, 'h0, 0, '0, 0);
    @(posedge clk); #1 drive(0, 0, '0, 0, '0, 0);
    @(negedge clk);
    check("restart id_valid", 64'(bus.id_valid), 64'd1);
    check("restart id_pc", 64'(bus.id_pc), 64'd0);
    check("restart id_instr", 64'(bus.id_instr), 64'(word_of('0)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
